// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block: mode encodings, counter
// direction and a helper that slices one channel's duty out of the packed bus.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Upper bounds for the generic duty extractor; callers cast in and out.
  localparam int DUTY_MAX_W   = 32;
  localparam int DUTY_BUS_MAX = 512;

  function automatic logic [DUTY_MAX_W-1:0] chan_duty(
    input logic [DUTY_BUS_MAX-1:0] bus,
    input int unsigned             ch,
    input int unsigned             w
  );
    logic [DUTY_BUS_MAX-1:0] ones;
    logic [DUTY_BUS_MAX-1:0] sel;
    ones = '1;
    sel  = (bus >> (ch * w)) & ~(ones << w);
    return sel[DUTY_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM counter: edge (sawtooth) or centre (triangle) sequencing, with
// period-boundary detection. en=0 parks the counter at 0 counting up.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] cnt,
  output logic             boundary,
  output logic             cnt_zero
);

  dir_e             dir;
  dir_e             dir_next;
  logic [WIDTH-1:0] cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else begin
      cnt <= cnt_next;
      dir <= dir_next;
    end
  end

  always_comb begin
    cnt_next = cnt;
    dir_next = dir;
    if (!en) begin
      cnt_next = '0;
      dir_next = DIR_UP;
    end else if (mode == MODE_EDGE) begin
      dir_next = DIR_UP;
      cnt_next = (cnt >= top) ? '0 : cnt + WIDTH'(1);
    end else if (dir == DIR_UP) begin
      if (cnt >= top) begin
        // top of 0 or 1 has no descending leg; fall straight back to 0
        if (top <= WIDTH'(1)) begin
          cnt_next = '0;
          dir_next = DIR_UP;
        end else begin
          cnt_next = cnt - WIDTH'(1);
          dir_next = DIR_DOWN;
        end
      end else begin
        cnt_next = cnt + WIDTH'(1);
      end
    end else begin
      if (cnt <= WIDTH'(1)) begin
        cnt_next = '0;
        dir_next = DIR_UP;
      end else begin
        cnt_next = cnt - WIDTH'(1);
      end
    end
  end

  assign boundary = en && (cnt_next == '0);
  assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/pwm_multi_channel.sv
// NUM_CH-output PWM generator on a shared timebase with double-buffered
// mode/top/duty that move from shadow to active only at period boundaries.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NUM_CH      = 3,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic [WIDTH-1:0]        top,
  input  logic [NUM_CH*WIDTH-1:0] duty,
  input  logic                    load,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_start,
  output logic                    update_pending
);

  localparam logic [NUM_CH-1:0] INACTIVE = ACTIVE_HIGH ? '0 : '1;

  logic             mode_s;
  logic             mode_a;
  logic [WIDTH-1:0] top_s;
  logic [WIDTH-1:0] top_a;
  logic [WIDTH-1:0] cnt;
  logic             boundary;
  logic             cnt_zero;
  logic             xfer;
  logic [NUM_CH-1:0] raw;

  pwm_timebase #(.WIDTH(WIDTH)) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode_a),
    .top      (top_a),
    .cnt      (cnt),
    .boundary (boundary),
    .cnt_zero (cnt_zero)
  );

  // load is a single-cycle strobe with no back-pressure: whatever is on
  // mode/top/duty in that cycle is captured; a later strobe overwrites it.
  // While disabled the block behaves as if every cycle were a boundary.
  assign xfer = !en || boundary;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_s         <= MODE_EDGE;
      mode_a         <= MODE_EDGE;
      top_s          <= '0;
      top_a          <= '0;
      update_pending <= 1'b0;
    end else if (xfer) begin
      if (load) begin
        mode_s <= mode;
        top_s  <= top;
        mode_a <= mode;
        top_a  <= top;
      end else begin
        mode_a <= mode_s;
        top_a  <= top_s;
      end
      update_pending <= 1'b0;
    end else if (load) begin
      mode_s         <= mode;
      top_s          <= top;
      update_pending <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [WIDTH-1:0] duty_in;
    logic [WIDTH-1:0] duty_s;
    logic [WIDTH-1:0] duty_a;

    assign duty_in = WIDTH'(chan_duty(DUTY_BUS_MAX'(duty), g, WIDTH));

    always_ff @(posedge clk) begin
      if (rst) begin
        duty_s <= '0;
        duty_a <= '0;
      end else if (xfer) begin
        if (load) begin
          duty_s <= duty_in;
          duty_a <= duty_in;
        end else begin
          duty_a <= duty_s;
        end
      end else if (load) begin
        duty_s <= duty_in;
      end
    end

    assign raw[g] = (cnt < duty_a);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out      <= INACTIVE;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= en ? (raw ^ INACTIVE) : INACTIVE;
      period_start <= en && cnt_zero;
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: an active-high and an active-low instance share
// stimulus; a period-position reference model feeds an expected-value queue.
module tb_pwm_multi_channel;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int SW = 2 * (N + 2);

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst  = 1'b1;
  logic           en   = 1'b0;
  logic           mode = 1'b0;
  logic           load = 1'b0;
  logic [W-1:0]   top  = '0;
  logic [N*W-1:0] duty = '0;

  logic [N-1:0] pwm_out,   pwm_out_n;
  logic         period_start, period_start_n;
  logic         update_pending, update_pending_n;

  pwm_multi_channel #(.WIDTH(W), .NUM_CH(N), .ACTIVE_HIGH(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .top(top), .duty(duty), .load(load),
    .pwm_out(pwm_out), .period_start(period_start), .update_pending(update_pending)
  );

  pwm_multi_channel #(.WIDTH(W), .NUM_CH(N), .ACTIVE_HIGH(1'b0)) dut_n (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .top(top), .duty(duty), .load(load),
    .pwm_out(pwm_out_n), .period_start(period_start_n), .update_pending(update_pending_n)
  );

  // scoreboard
  logic [SW-1:0] exp_q[$];
  int nvec = 0;
  int nerr = 0;

  // reference model state: p is the position inside the current period
  int         p = 0;
  logic       m_mode_a = 1'b0, m_mode_s = 1'b0, m_pend = 1'b0;
  logic [7:0] m_top_a = '0, m_top_s = '0;
  logic [7:0] m_duty_a[N] = '{default: '0};
  logic [7:0] m_duty_s[N] = '{default: '0};

  int hi0, hi1, hi2, n_ps, n_pend;
  logic [15:0] hist;

  function automatic int plen(logic md, logic [7:0] t);
    if (md == 1'b0) return int'(t) + 1;
    return (t == 0) ? 1 : 2 * int'(t);
  endfunction

  function automatic int cnt_of(int pp, logic md, logic [7:0] t);
    if (md == 1'b0 || pp <= int'(t)) return pp;
    return 2 * int'(t) - pp;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    hi0 = 0; hi1 = 0; hi2 = 0; n_ps = 0; n_pend = 0; hist = '0;
  endtask

  // driver: one clock with the currently driven inputs, then check outputs
  task automatic cyc();
    logic [N-1:0]  raw, e_pwm;
    logic          e_ps, bnd;
    logic [SW-1:0] e, got;
    int            c;
    c = cnt_of(p, m_mode_a, m_top_a);
    for (int i = 0; i < N; i++) raw[i] = (c < int'(m_duty_a[i]));
    if (rst) begin
      e_pwm = '0; e_ps = 1'b0; p = 0;
      m_mode_a = 1'b0; m_mode_s = 1'b0; m_top_a = '0; m_top_s = '0; m_pend = 1'b0;
      for (int i = 0; i < N; i++) begin m_duty_a[i] = '0; m_duty_s[i] = '0; end
    end else begin
      e_pwm = en ? raw : '0;
      e_ps  = en && (c == 0);
      bnd   = en && (p == plen(m_mode_a, m_top_a) - 1);
      if (!en || bnd) begin
        if (load) begin
          m_mode_s = mode; m_top_s = top;
          for (int i = 0; i < N; i++) m_duty_s[i] = duty[i*W +: W];
        end
        m_mode_a = m_mode_s; m_top_a = m_top_s;
        for (int i = 0; i < N; i++) m_duty_a[i] = m_duty_s[i];
        m_pend = 1'b0;
        p = 0;
      end else begin
        if (load) begin
          m_mode_s = mode; m_top_s = top;
          for (int i = 0; i < N; i++) m_duty_s[i] = duty[i*W +: W];
          m_pend = 1'b1;
        end
        p = p + 1;
      end
    end
    e = {e_pwm, e_ps, m_pend, ~e_pwm, e_ps, m_pend};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = {pwm_out, period_start, update_pending, pwm_out_n, period_start_n, update_pending_n};
    chk("cycle", 32'(got), 32'(exp_q.pop_front()));
    hi0 += int'(pwm_out[0]); hi1 += int'(pwm_out[1]); hi2 += int'(pwm_out[2]);
    n_ps += int'(period_start); n_pend += int'(update_pending);
    hist = {hist[14:0], pwm_out[0]};
    load = 1'b0;
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic do_load(logic md, logic [7:0] t, logic [7:0] d0, logic [7:0] d1, logic [7:0] d2);
    mode = md; top = t; duty = {d2, d1, d0}; load = 1'b1;
    cyc();
  endtask

  task automatic wait_p(int target);
    int guard;
    guard = 0;
    while (p != target && guard < 400) begin
      cyc();
      guard++;
    end
    chk("reach_cnt", 32'(p), 32'(target));
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    // reset state of both polarities
    run(2);
    rst = 1'b0;

    // edge mode, full period, duties 64 / 0 / 255
    en = 1'b1;
    do_load(1'b0, 8'd255, 8'd64, 8'd0, 8'd255);
    clr();
    run(512);
    chk("edge_ch0_high", hi0, 128);
    chk("edge_ch1_high", hi1, 0);
    chk("edge_ch2_high", hi2, 510);
    chk("edge_period_start", n_ps, 2);

    // small period: duty above top is constant active
    pulse_rst();
    do_load(1'b0, 8'd9, 8'd10, 8'd5, 8'd0);
    clr();
    run(20);
    chk("small_ch0_full", hi0, 20);
    chk("small_ch1_half", hi1, 10);
    chk("small_period_start", n_ps, 2);

    // centre mode, top 4, duty 2
    pulse_rst();
    do_load(1'b1, 8'd4, 8'd2, 8'd0, 8'd0);
    clr();
    run(16);
    chk("centre_pattern", 32'(hist), 32'(16'b1100_0001_1100_0001));
    chk("centre_period_start", n_ps, 2);

    // duty update mid-period lands at the next boundary
    pulse_rst();
    do_load(1'b0, 8'd99, 8'd30, 8'd0, 8'd0);
    wait_p(50);
    clr();
    do_load(1'b0, 8'd99, 8'd70, 8'd0, 8'd0);
    run(149);
    chk("glitch_ch0_high", hi0, 70);
    chk("glitch_pending", n_pend, 49);
    chk("glitch_period_start", n_ps, 1);

    // load exactly on the boundary cycle
    wait_p(99);
    clr();
    do_load(1'b0, 8'd99, 8'd10, 8'd0, 8'd0);
    run(100);
    chk("bnd_ch0_high", hi0, 10);
    chk("bnd_pending", n_pend, 0);

    // reset mid-period discards a pending load
    wait_p(20);
    do_load(1'b0, 8'd99, 8'd90, 8'd0, 8'd0);
    wait_p(37);
    pulse_rst();
    clr();
    run(100);
    chk("rst_pending", n_pend, 0);
    chk("rst_ch0_high", hi0, 0);

    // en low holds outputs inactive; restart from cnt 0
    do_load(1'b0, 8'd99, 8'd50, 8'd50, 8'd50);
    run(30);
    en = 1'b0;
    clr();
    run(5);
    chk("dis_outputs", hi0 + hi1 + hi2, 0);
    chk("dis_period_start", n_ps, 0);
    en = 1'b1;
    clr();
    run(100);
    chk("reen_ch0_high", hi0, 50);
    chk("reen_period_start", n_ps, 1);

    // random loads, modes, small tops and enable toggles
    repeat (400) begin
      if ($urandom_range(0, 9) == 0) begin
        mode = 1'($urandom_range(0, 1));
        top  = 8'($urandom_range(0, 12));
        duty = 24'($urandom);
        load = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) en = ~en;
      cyc();
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
